// File: rtl/riscv_mem_if_pkg.sv
// Shared definitions for the load/store bus adapter: access size codes,
// FSM state type and the alignment/legality helper.
package riscv_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE,
    ERR
  } state_t;

  // True when the access size is supported and the address is naturally aligned.
  function automatic logic access_ok(input logic [1:0] size, input logic [2:0] low,
                                     input logic has_double);
    case (size)
      SZ_B:    access_ok = 1'b1;
      SZ_H:    access_ok = ~low[0];
      SZ_W:    access_ok = (low[1:0] == 2'b00);
      default: access_ok = has_double && (low == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/riscv_mem_if_if.sv
// Valid/ready data bus between the adapter (master) and memory/interconnect (slave).
interface riscv_bus_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [NB-1:0]     be;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;
  logic              err;

  modport master (output valid, we, addr, wdata, be,
                  input  ready, rvalid, rdata, err);
  modport slave  (input  valid, we, addr, wdata, be,
                  output ready, rvalid, rdata, err);
endinterface

// File: rtl/riscv_mem_if_lane_align.sv
// Byte-lane steering: store replication, byte enables, and load lane
// extraction with sign/zero extension. Purely combinational.
module riscv_lane_align
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]                  size,
  input  logic                        uns,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  logic [XLEN-1:0]             st_data,
  input  logic [XLEN-1:0]             ld_word,
  output logic [XLEN-1:0]             st_rep,
  output logic [XLEN/8-1:0]           be,
  output logic [XLEN-1:0]             ld_ext
);
  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sign_bit;

  // Replicate the store value across every lane and enable only the addressed bytes.
  always_comb begin
    st_rep = st_data;
    be     = '1;
    case (size)
      SZ_B: begin
        st_rep = {NB{st_data[7:0]}};
        be     = NB'(1) << off;
      end
      SZ_H: begin
        st_rep = {(NB/2){st_data[15:0]}};
        be     = NB'(3) << off;
      end
      SZ_W: begin
        st_rep = {(NB/4){st_data[31:0]}};
        be     = NB'(4'hF) << off;
      end
      default: ;
    endcase
  end

  // Shift the addressed lane down to bit 0, then mask and fill the upper bits.
  always_comb begin
    shifted  = ld_word >> {off, 3'b000};
    mask     = '1;
    sign_bit = 1'b0;
    case (size)
      SZ_B: begin
        mask     = XLEN'(8'hFF);
        sign_bit = shifted[7];
      end
      SZ_H: begin
        mask     = XLEN'(16'hFFFF);
        sign_bit = shifted[15];
      end
      SZ_W: begin
        mask     = XLEN'(32'hFFFF_FFFF);
        sign_bit = shifted[31];
      end
      default: ;
    endcase
    ld_ext = (shifted & mask) | ((sign_bit & ~uns) ? ~mask : '0);
  end

endmodule

// File: rtl/riscv_mem_if.sv
// Load/store adapter from the core's memory port to a variable-latency
// valid/ready bus. Optional bus wait limit enabled by RISCV_MEM_IF_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for core_req; illegal/misaligned requests go straight to ERR
// REQ    | bus_valid high with latched payload until bus_ready
// WAIT_R | load accepted, waiting for bus_rvalid
// DONE   | one-cycle core_done pulse
// ERR    | one-cycle core_err pulse
module riscv_mem_if
  import riscv_mem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [1:0]        core_size,
  input  logic              core_uns,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [XLEN-1:0]   core_wdata,
  output logic [XLEN-1:0]   core_rdata,
  output logic              core_stall,
  output logic              core_done,
  output logic              core_err,
  riscv_bus_if.master       bus
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;

  logic              legal;
  logic              handshake;
  logic              timeout;
  logic [XLEN-1:0]   st_rep;
  logic [NB-1:0]     st_be;
  logic [XLEN-1:0]   ld_ext;

  assign legal     = access_ok(core_size, core_addr[2:0], XLEN == 64);
  assign handshake = (state_q == REQ) && bus.ready;

  riscv_lane_align #(.XLEN(XLEN)) u_align (
    .size    (size_q),
    .uns     (uns_q),
    .off     (addr_q[OFF_W-1:0]),
    .st_data (wdata_q),
    .ld_word (bus.rdata),
    .st_rep  (st_rep),
    .be      (st_be),
    .ld_ext  (ld_ext)
  );

`ifdef RISCV_MEM_IF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent on the bus; restart whenever a new request is issued.
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (state_q == IDLE)
      cnt_q <= '0;
    else if (state_q == REQ || state_q == WAIT_R)
      cnt_q <= cnt_q + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a response in the limit cycle still wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (core_req) state_d = legal ? REQ : ERR;
      REQ:    if (handshake) state_d = we_q ? DONE : WAIT_R;
              else if (timeout) state_d = ERR;
      WAIT_R: if (bus.rvalid) state_d = bus.err ? ERR : DONE;
              else if (timeout) state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // Latch the request payload so the bus side stays stable while the core is frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      wdata_q <= '0;
    end else if (state_q == IDLE && core_req && legal) begin
      addr_q  <= core_addr;
      we_q    <= core_we;
      size_q  <= core_size;
      uns_q   <= core_uns;
      wdata_q <= core_wdata;
    end
  end

  // Load result is only updated by an error-free response.
  always_ff @(posedge clk) begin
    if (reset)
      rdata_q <= '0;
    else if (state_q == WAIT_R && bus.rvalid && !bus.err)
      rdata_q <= ld_ext;
  end

  assign bus.valid  = (state_q == REQ);
  assign bus.we     = (state_q == REQ) && we_q;
  assign bus.addr   = (state_q == REQ) ? {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)} : '0;
  assign bus.wdata  = (state_q == REQ) ? st_rep : '0;
  assign bus.be     = (state_q != REQ) ? '0 : (we_q ? st_be : '1);

  assign core_rdata = rdata_q;
  assign core_done  = (state_q == DONE);
  assign core_err   = (state_q == ERR);
  assign core_stall = ~reset & (((state_q == IDLE) && core_req) ||
                                (state_q == REQ) || (state_q == WAIT_R));

endmodule

// File: tb/tb_riscv_mem_if.sv
// Directed bench for riscv_mem_if (XLEN=32) with a response scoreboard.
module tb_riscv_mem_if;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, core_uns;
  logic [1:0]  core_size;
  logic [31:0] core_addr, core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall, core_done, core_err;

  riscv_bus_if #(.XLEN(32), .ADDR_W(32)) bus_i ();

  riscv_mem_if #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_size  (core_size),
    .core_uns   (core_uns),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .core_done  (core_done),
    .core_err   (core_err),
    .bus        (bus_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] m_be(input logic we, input logic [1:0] size, input logic [1:0] a);
    if (!we)               return 4'hF;
    else if (size == 2'd0) return 4'b0001 << a;
    else if (size == 2'd1) return 4'b0011 << a;
    else                   return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'd0)      return {4{w[7:0]}};
    else if (size == 2'd1) return {2{w[15:0]}};
    else                   return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                         input logic [1:0] a, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = w[8*a +: 16];
    if (size == 2'd0)      return uns ? {24'b0, b} : 32'($signed(b));
    else if (size == 2'd1) return uns ? {16'b0, h} : 32'($signed(h));
    else                   return w;
  endfunction

  // Issue one access, play the bus slave with the given delays, check the
  // payload every cycle it is offered and the completion against the scoreboard.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int rdy_dly, input int rv_dly, input logic berr,
                        input logic [31:0] rword, input logic to_exp,
                        output int lat, output logic saw_valid);
    exp_t e;
    logic legal, got, hs;
    int   wait_cnt, rv_cnt;
    legal = (size == 2'd0) || (size == 2'd1 && !addr[0]) || (size == 2'd2 && addr[1:0] == 2'b00);
    e.is_err = !legal || to_exp || (!we && berr);
    e.rdata  = (e.is_err || we) ? last_rdata : m_load(size, uns, addr[1:0], rword);
    last_rdata = e.rdata;
    sb.push_back(e);
    core_req = 1'b1; core_we = we; core_size = size; core_uns = uns;
    core_addr = addr; core_wdata = wdata;
    lat = 0; saw_valid = 1'b0; got = 1'b0; hs = 1'b0; wait_cnt = 0; rv_cnt = 0;
    #1;
    for (int c = 1; c <= 60 && !got; c++) begin
      bus_i.ready = 1'b0; bus_i.rvalid = 1'b0; bus_i.err = 1'b0; bus_i.rdata = '0;
      if (core_done || core_err) begin
        exp_t x;
        got = 1'b1;
        lat = c;
        x = sb.pop_front();
        chk("done_pulse", {31'b0, core_done}, {31'b0, !x.is_err});
        chk("err_pulse", {31'b0, core_err}, {31'b0, x.is_err});
        chk("core_rdata", core_rdata, x.rdata);
        chk("stall_at_end", {31'b0, core_stall}, 32'd0);
      end else begin
        chk("stall_busy", {31'b0, core_stall}, 32'd1);
        if (bus_i.valid) begin
          saw_valid = 1'b1;
          chk("bus_addr", bus_i.addr, addr & ~32'd3);
          chk("bus_be", {28'b0, bus_i.be}, {28'b0, m_be(we, size, addr[1:0])});
          chk("bus_we", {31'b0, bus_i.we}, {31'b0, we});
          if (we) chk("bus_wdata", bus_i.wdata, m_wdata(size, wdata));
          if (wait_cnt >= rdy_dly) begin
            bus_i.ready = 1'b1;
            hs = 1'b1;
          end else wait_cnt++;
        end else if (hs && !we) begin
          if (rv_cnt >= rv_dly) begin
            bus_i.rvalid = 1'b1; bus_i.rdata = rword; bus_i.err = berr;
          end else rv_cnt++;
        end
        step();
        core_req = 1'b0;
        #1;
      end
    end
    if (!got) begin
      chk("response_seen", {31'b0, got}, 32'd1);
      void'(sb.pop_front());
    end
    step();
    chk("no_second_done", {31'b0, core_done}, 32'd0);
    chk("no_late_err", {31'b0, core_err}, 32'd0);
    chk("stall_idle", {31'b0, core_stall}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic sv;
    reset = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_size = 2'd0; core_uns = 1'b0;
    core_addr = '0; core_wdata = '0;
    bus_i.ready = 1'b0; bus_i.rvalid = 1'b0; bus_i.rdata = '0; bus_i.err = 1'b0;
    step(); step();
    chk("rst_rdata", core_rdata, 32'd0);
    chk("rst_valid", {31'b0, bus_i.valid}, 32'd0);
    chk("rst_be", {28'b0, bus_i.be}, 32'd0);
    chk("rst_addr", bus_i.addr, 32'd0);
    chk("rst_outs", {28'b0, core_stall, core_done, core_err, bus_i.we}, 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_stall", {31'b0, core_stall}, 32'd0);

    // lb, sign-extended top lane, zero-wait bus
    access(1'b0, SZ_B, 1'b0, 32'h103, 32'h0, 0, 0, 1'b0, 32'h80FF_FF00, 1'b0, lat, sv);
    chk("lb_latency", lat, 32'd4);
    // sh to upper half
    access(1'b1, SZ_H, 1'b0, 32'h202, 32'h1234_ABCD, 0, 0, 1'b0, 32'h0, 1'b0, lat, sv);
    chk("sh_latency", lat, 32'd3);
    // misaligned lw never reaches the bus
    access(1'b0, SZ_W, 1'b0, 32'h101, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0, lat, sv);
    chk("mis_latency", lat, 32'd2);
    chk("mis_no_valid", {31'b0, sv}, 32'd0);
    // misaligned half
    access(1'b1, SZ_H, 1'b0, 32'h203, 32'h55, 0, 0, 1'b0, 32'h0, 1'b0, lat, sv);
    chk("mis_h_no_valid", {31'b0, sv}, 32'd0);
    // illegal double on a 32-bit datapath
    access(1'b0, SZ_D, 1'b0, 32'h208, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0, lat, sv);
    chk("dbl_no_valid", {31'b0, sv}, 32'd0);
    // slow bus: ready after 5 cycles, rvalid 3 cycles after that
    access(1'b0, SZ_W, 1'b0, 32'h104, 32'h0, 5, 3, 1'b0, 32'hDEAD_BEEF, 1'b0, lat, sv);
    chk("slow_latency", lat, 32'd12);
    // load extension variants
    access(1'b0, SZ_B, 1'b1, 32'h101, 32'h0, 0, 0, 1'b0, 32'h80FF_FF00, 1'b0, lat, sv);
    access(1'b0, SZ_H, 1'b0, 32'h102, 32'h0, 0, 1, 1'b0, 32'h80FF_1234, 1'b0, lat, sv);
    access(1'b0, SZ_H, 1'b1, 32'h100, 32'h0, 1, 0, 1'b0, 32'h0000_9ABC, 1'b0, lat, sv);
    // byte stores at every offset
    for (int a = 0; a < 4; a++)
      access(1'b1, SZ_B, 1'b0, 32'h300 + a, 32'h0000_00A5 + a, a, 0, 1'b0, 32'h0, 1'b0, lat, sv);
    // lhu with bus error: error pulse, previous load data kept
    access(1'b0, SZ_H, 1'b1, 32'h106, 32'h0, 0, 2, 1'b1, 32'hFFFF_FFFF, 1'b0, lat, sv);

    // reset while waiting for the load response
    core_req = 1'b1; core_we = 1'b0; core_size = SZ_W; core_uns = 1'b0;
    core_addr = 32'h500; core_wdata = '0;
    step();
    core_req = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, bus_i.valid}, 32'd1);
    bus_i.ready = 1'b1;
    step();
    bus_i.ready = 1'b0;
    chk("rst_wait_stall", {31'b0, core_stall}, 32'd1);
    reset = 1'b1;
    step();
    chk("rst_mid_valid", {31'b0, bus_i.valid}, 32'd0);
    chk("rst_mid_stall", {31'b0, core_stall}, 32'd0);
    chk("rst_mid_pulses", {30'b0, core_done, core_err}, 32'd0);
    chk("rst_mid_rdata", core_rdata, 32'd0);
    last_rdata = '0;
    reset = 1'b0;
    bus_i.rvalid = 1'b1; bus_i.rdata = 32'h1111_2222;
    step();
    bus_i.rvalid = 1'b0;
    chk("stray_rvalid_pulses", {30'b0, core_done, core_err}, 32'd0);
    step();
    chk("stray_rvalid_pulses2", {30'b0, core_done, core_err}, 32'd0);
    chk("stray_rvalid_rdata", core_rdata, 32'd0);

`ifdef RISCV_MEM_IF_TIMEOUT_EN
    // bus never accepts: error after 8 cycles in REQ
    access(1'b0, SZ_W, 1'b0, 32'h600, 32'h0, 1000, 0, 1'b0, 32'h0, 1'b1, lat, sv);
    chk("timeout_latency", lat, 32'd10);
`endif

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
